// File: rtl/approx_tree_pkg.sv
// Shared definitions for the approximate adder-tree front end.
// Holds lane/sample geometry, the tree mode encoding, and the per-stage
// combine function used by the 3-stage tree.
package approx_tree_pkg;

  localparam int unsigned LANES      = 8;
  localparam int unsigned SAMPLE_W   = 8;
  localparam int unsigned TREE_W     = 11;
  localparam int unsigned APPROX_LSB = 3;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_e;

  // One adder node of the tree. Exact mode is a full add. Approx mode adds
  // only the bits above APPROX_LSB and ORs the low bits together. Operands
  // are carried at the full tree width; the real per-stage widths (9/10/11)
  // follow from the input range, so no carry is lost in either mode.
  function automatic logic [TREE_W-1:0] tree_combine(
    input logic [TREE_W-1:0] a,
    input logic [TREE_W-1:0] b,
    input mode_e             m
  );
    logic [TREE_W-1:0] r;
    r = '0;
    if (m == MODE_APPROX) begin
      r[TREE_W-1:APPROX_LSB] = a[TREE_W-1:APPROX_LSB] + b[TREE_W-1:APPROX_LSB];
      r[APPROX_LSB-1:0]      = a[APPROX_LSB-1:0] | b[APPROX_LSB-1:0];
    end else begin
      r = a + b;
    end
    return r;
  endfunction

endpackage

// File: rtl/approx_tree_sched_if.sv
// Handshake bundle for approx_tree_sched.
//   s_valid/s_data/s_ready : sample stream in (valid/ready)
//   mode                   : tree mode request, sampled on first sample of a frame
//   out_valid/out_data/out_mode/out_ready : frame sum out (valid/ready)
//   busy                   : frame partially collected or group in the tree
// slave  = the scheduler side, master = source/consumer side.
interface approx_tree_sched_if
  import approx_tree_pkg::*;
#(
  parameter int unsigned ACC_W = 13
);

  logic                s_valid;
  logic [SAMPLE_W-1:0] s_data;
  logic                s_ready;
  logic                mode;
  logic                out_valid;
  logic [ACC_W-1:0]    out_data;
  logic                out_mode;
  logic                out_ready;
  logic                busy;

  modport slave (
    input  s_valid, s_data, mode, out_ready,
    output s_ready, out_valid, out_data, out_mode, busy
  );

  modport master (
    output s_valid, s_data, mode, out_ready,
    input  s_ready, out_valid, out_data, out_mode, busy
  );

endinterface

// File: rtl/approx_tree8.sv
// Registered 3-stage, 8-input adder tree (exact or OR-LSB approximate).
//   clk, rst_n : clock, async active-low reset
//   lanes      : 8 unsigned samples, captured by stage 1 every cycle
//   mode       : combine mode for the group entering stage 1
//   y          : tree sum, 3 cycles after capture
//   y_mode     : mode that produced y (travels with the data)
// Free-running: no enable; validity is tracked by the caller.
module approx_tree8
  import approx_tree_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] lanes [LANES],
  input  mode_e               mode,
  output logic [TREE_W-1:0]   y,
  output mode_e               y_mode
);

  logic [TREE_W-1:0] s1 [4];
  logic [TREE_W-1:0] s2 [2];
  logic [TREE_W-1:0] s1_next [4];
  logic [TREE_W-1:0] s2_next [2];
  logic [TREE_W-1:0] y_next;
  mode_e             m1, m2;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      s1_next[i] = tree_combine(TREE_W'(lanes[2*i]), TREE_W'(lanes[2*i+1]), mode);
    end
    for (int unsigned i = 0; i < 2; i++) begin
      s2_next[i] = tree_combine(s1[2*i], s1[2*i+1], m1);
    end
    y_next = tree_combine(s2[0], s2[1], m2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) s1[i] <= '0;
      for (int unsigned i = 0; i < 2; i++) s2[i] <= '0;
      y      <= '0;
      m1     <= MODE_EXACT;
      m2     <= MODE_EXACT;
      y_mode <= MODE_EXACT;
    end else begin
      for (int unsigned i = 0; i < 4; i++) s1[i] <= s1_next[i];
      for (int unsigned i = 0; i < 2; i++) s2[i] <= s2_next[i];
      y      <= y_next;
      m1     <= mode;
      m2     <= m1;
      y_mode <= m2;
    end
  end

endmodule

// File: rtl/approx_tree_sched.sv
// Streaming front end for the 8-input approximate adder tree.
// Packs accepted samples into 8-lane groups, issues each full group to the
// tree, and accumulates FRAME_GROUPS tree results into one frame sum.
//   clk, rst_n : clock, async active-low reset
//   bus        : sample in / frame sum out handshakes, mode, busy
module approx_tree_sched
  import approx_tree_pkg::*;
#(
  parameter int unsigned FRAME_GROUPS = 4,
  parameter int unsigned ACC_W        = TREE_W + $clog2(FRAME_GROUPS)
)(
  input  logic               clk,
  input  logic               rst_n,
  approx_tree_sched_if.slave bus
);

  localparam int unsigned GRP_W = (FRAME_GROUPS > 1) ? $clog2(FRAME_GROUPS) : 1;
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(FRAME_GROUPS - 1);

  logic [2:0]          lane_cnt;
  logic [GRP_W-1:0]    grp_cnt;
  logic [SAMPLE_W-1:0] lane_buf [LANES];
  mode_e               frame_mode;
  logic                iss, iss_last;
  logic [2:0]          v, v_last;
  logic [ACC_W-1:0]    acc;
  logic                out_valid_r;
  logic [ACC_W-1:0]    out_data_r;
  logic                out_mode_r;
  logic [TREE_W-1:0]   tree_y;
  mode_e               tree_mode;

  logic s_ready_c, accept, lane_last, grp_last;

  always_comb begin
    lane_last = (lane_cnt == 3'd7);
    grp_last  = (grp_cnt == GRP_LAST);
    // Only the frame-closing sample is held off, and only while the output
    // register still holds the previous frame's sum.
    s_ready_c = !(out_valid_r && lane_last && grp_last);
    accept    = bus.s_valid && s_ready_c;
  end

  assign bus.s_ready   = s_ready_c;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_mode  = out_mode_r;
  assign bus.busy      = (lane_cnt != 3'd0) || (grp_cnt != '0) || (|v) || iss;

  // Collection side. grp_cnt advances on the group-closing acceptance itself
  // so the very next accepted sample already sees a fresh frame and can
  // latch frame_mode; the last-group flag rides the valid pipe instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt   <= '0;
      grp_cnt    <= '0;
      frame_mode <= MODE_EXACT;
      iss        <= 1'b0;
      iss_last   <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) lane_buf[i] <= '0;
    end else begin
      iss      <= accept && lane_last;
      iss_last <= accept && lane_last && grp_last;
      if (accept) begin
        lane_buf[lane_cnt] <= bus.s_data;
        lane_cnt           <= lane_cnt + 3'd1;
        if (lane_cnt == 3'd0 && grp_cnt == '0) begin
          frame_mode <= mode_e'(bus.mode);
        end
        if (lane_last) begin
          grp_cnt <= grp_last ? '0 : grp_cnt + GRP_W'(1);
        end
      end
    end
  end

  // Tree tracking, accumulation and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v           <= '0;
      v_last      <= '0;
      acc         <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_mode_r  <= 1'b0;
    end else begin
      v      <= {v[1:0], iss};
      v_last <= {v_last[1:0], iss_last};
      if (v[2]) begin
        if (v_last[2]) begin
          acc <= '0;
        end else begin
          acc <= acc + ACC_W'(tree_y);
        end
      end
      // A landing frame result takes priority over a consumer handshake.
      if (v[2] && v_last[2]) begin
        out_valid_r <= 1'b1;
        out_data_r  <= acc + ACC_W'(tree_y);
        out_mode_r  <= tree_mode;
      end else if (out_valid_r && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  approx_tree8 u_tree (
    .clk    (clk),
    .rst_n  (rst_n),
    .lanes  (lane_buf),
    .mode   (frame_mode),
    .y      (tree_y),
    .y_mode (tree_mode)
  );

endmodule

// File: tb/tb_approx_tree_sched.sv
// Bench for approx_tree_sched: behavioural frame-sum model checked every
// cycle at the falling edge, plus literal expectations for directed cases.
module tb_approx_tree_sched;
  import approx_tree_pkg::*;

  localparam int unsigned FG    = 4;
  localparam int unsigned ACC_W = TREE_W + $clog2(FG);
  localparam int          FRAME = 8 * FG;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  approx_tree_sched_if #(.ACC_W(ACC_W)) bus ();

  approx_tree_sched #(.FRAME_GROUPS(FG), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int or_ctl = 1;   // 0: out_ready low, 1: high, 2: random

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (or_ctl)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference tree: pairwise reduction over plain integers.
  function automatic int tree_ref(input int s[8], input int approx);
    int lvl[8];
    int n;
    lvl = s;
    n = 8;
    while (n > 1) begin
      for (int i = 0; i < n / 2; i++) begin
        int a, b;
        a = lvl[2*i];
        b = lvl[2*i+1];
        lvl[i] = approx ? ((((a >> 3) + (b >> 3)) << 3) | ((a | b) & 7)) : (a + b);
      end
      n = n / 2;
    end
    return lvl[0];
  endfunction

  // Model state (value seen between edges)
  int m_cnt, m_fsum, m_fmode, m_age, m_pend_last, m_pend_sum, m_pend_mode;
  int m_ov, m_od, m_om;
  int m_grp[8];
  int n_taken = 0;
  logic [31:0] cap_data, cap_mode;

  task automatic model_reset();
    m_cnt = 0; m_fsum = 0; m_fmode = 0; m_age = 0;
    m_pend_last = 0; m_pend_sum = 0; m_pend_mode = 0;
    m_ov = 0; m_od = 0; m_om = 0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_s_ready",   32'(bus.s_ready),   1);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_data",  32'(bus.out_data),  0);
      chk("rst_out_mode",  32'(bus.out_mode),  0);
      chk("rst_busy",      32'(bus.busy),      0);
      model_reset();
    end else begin
      int sready, acc_s, take, deliver, g;
      sready = !(m_ov && m_cnt == FRAME - 1);
      chk("s_ready",   32'(bus.s_ready),   32'(sready));
      chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
      if (m_ov) begin
        chk("out_data", 32'(bus.out_data), 32'(m_od));
        chk("out_mode", 32'(bus.out_mode), 32'(m_om));
      end
      chk("busy", 32'(bus.busy), 32'((m_cnt != 0) || (m_age > 0)));

      acc_s   = (bus.s_valid === 1'b1) && sready;
      take    = m_ov && (bus.out_ready === 1'b1);
      deliver = (m_age == 1) && m_pend_last;
      if (take) begin
        cap_data = 32'(bus.out_data);
        cap_mode = 32'(bus.out_mode);
        n_taken++;
      end
      if (m_age > 0) m_age--;
      if (deliver) begin
        m_ov = 1; m_od = m_pend_sum; m_om = m_pend_mode; m_pend_last = 0;
      end else if (take) begin
        m_ov = 0;
      end
      if (acc_s) begin
        if (m_cnt == 0) m_fmode = int'(bus.mode);
        m_grp[m_cnt % 8] = int'(bus.s_data);
        m_cnt++;
        if (m_cnt % 8 == 0) begin
          g = tree_ref(m_grp, m_fmode);
          m_age = 4;
          if (m_cnt == FRAME) begin
            m_pend_last = 1;
            m_pend_sum  = m_fsum + g;
            m_pend_mode = m_fmode;
            m_fsum = 0;
            m_cnt  = 0;
          end else begin
            m_fsum += g;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int data, input int m);
    int t;
    logic ok;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'(data);
    bus.mode    = m[0];
    t = 0;
    ok = 1'b0;
    while (!ok && t < 500) begin
      ok = bus.s_ready;
      tick();
      t++;
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    bus.s_data  = 8'($urandom);
    repeat (n) tick();
  endtask

  // kind 0: all 0xFF, 1: groups of 1..8, 2: random
  task automatic send_frame(input int kind, input int m0, input int sw, input int m1, input int gapmax);
    for (int i = 0; i < FRAME; i++) begin
      int d;
      if (gapmax > 0 && $urandom_range(0, 2) == 0) idle($urandom_range(1, gapmax));
      d = (kind == 0) ? 255 : (kind == 1) ? (i % 8) + 1 : int'($urandom_range(0, 255));
      send(d, (i < sw) ? m0 : m1);
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_take(input int prev);
    int t = 0;
    while (n_taken == prev && t < 300) begin
      tick();
      t++;
    end
    if (n_taken == prev) chk("take_timeout", 0, 1);
  endtask

  task automatic do_reset();
    bus.s_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int s8[8];
    int prev, lat, blocked;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.mode    = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Pin the reference tree itself.
    for (int i = 0; i < 8; i++) s8[i] = i + 1;
    chk("ref_1to8_approx", 32'(tree_ref(s8, 1)), 15);
    chk("ref_1to8_exact",  32'(tree_ref(s8, 0)), 36);
    for (int i = 0; i < 8; i++) s8[i] = 255;
    chk("ref_ff_approx", 32'(tree_ref(s8, 1)), 1991);
    chk("ref_ff_exact",  32'(tree_ref(s8, 0)), 2040);

    // Exact 0xFF frame with latency.
    or_ctl = 1;
    prev = n_taken;
    send_frame(0, 0, FRAME, 0, 0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 4);
    wait_take(prev);
    chk("exact_ff_sum",  cap_data, 8160);
    chk("exact_ff_mode", cap_mode, 0);

    // Approx 0xFF frame.
    prev = n_taken;
    send_frame(0, 1, FRAME, 1, 0);
    wait_take(prev);
    chk("approx_ff_sum",  cap_data, 7964);
    chk("approx_ff_mode", cap_mode, 1);

    // Groups of 1..8, approx then exact.
    prev = n_taken;
    send_frame(1, 1, FRAME, 1, 0);
    wait_take(prev);
    chk("approx_1to8_sum", cap_data, 60);
    prev = n_taken;
    send_frame(1, 0, FRAME, 0, 0);
    wait_take(prev);
    chk("exact_1to8_sum", cap_data, 144);

    // Backpressure: hold a result, stream the next frame.
    idle(4);
    or_ctl = 0;
    idle(2);
    prev = n_taken;
    send_frame(0, 0, FRAME, 0, 0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("bp_first_valid", 32'(bus.out_valid), 1);
    for (int i = 0; i < FRAME - 1; i++) send((i % 8) + 1, 1);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'd8;
    bus.mode    = 1'b1;
    blocked = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.s_ready) blocked++;
      tick();
    end
    chk("bp_accepts_while_full", 32'(blocked), 0);
    chk("bp_s_ready_low", 32'(bus.s_ready), 0);
    or_ctl = 1;
    send(8, 1);
    bus.s_valid = 1'b0;
    wait_take(prev);
    chk("bp_first_sum", cap_data, 8160);
    wait_take(prev + 1);
    chk("bp_second_sum",  cap_data, 60);
    chk("bp_second_mode", cap_mode, 1);

    // Mode toggled mid-frame is ignored.
    prev = n_taken;
    send_frame(0, 1, 10, 0, 0);
    wait_take(prev);
    chk("toggle_sum",  cap_data, 7964);
    chk("toggle_mode", cap_mode, 1);

    // Reset mid-frame, then a clean frame.
    for (int i = 0; i < 20; i++) send(200, 0);
    do_reset();
    prev = n_taken;
    send_frame(0, 0, FRAME, 0, 0);
    wait_take(prev);
    chk("after_rst_sum", cap_data, 8160);

    // Reset while the final group is in the tree.
    idle(3);
    prev = n_taken;
    send_frame(1, 0, FRAME, 0, 0);
    idle(2);
    do_reset();
    idle(10);
    chk("rst_inflight_no_output", 32'(n_taken), 32'(prev));
    send_frame(1, 0, FRAME, 0, 0);
    wait_take(prev);
    chk("after_rst2_sum", cap_data, 144);

    // Random traffic with throttled consumer.
    idle(2);
    prev = n_taken;
    or_ctl = 2;
    for (int f = 0; f < 200; f++) begin
      int m;
      m = int'($urandom_range(0, 1));
      send_frame(2, m, int'($urandom_range(1, FRAME)), 1 - m, 3);
    end
    or_ctl = 1;
    idle(30);
    chk("random_frame_count", 32'(n_taken - prev), 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
